puc_cpu_core: RTL and testbench

Parametrised accumulator CPU core, the next generation of the PUC CPU: configurable data/PC/opcode widths, a register file of NUM_REGISTERS entries, NUM_SWITCHES input switches, a loadable program memory, and run/step/halt control. It sits beneath the board top level, takes switch inputs and a program-load port, and exposes pc, accumulator, opcode and a selectable register for LEDs and debug.

---
 rtl/puc_pkg.sv | 39 +++
 rtl/puc_program_mem.sv | 37 +++
 rtl/puc_cpu_core.sv | 220 ++++++++++++++++++++++
 tb/tb_puc_cpu_core.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puc_pkg.sv
// rtl/puc_pkg.sv - shared states, opcodes and instruction field helpers for the PUC core
package puc_pkg;

    typedef enum logic [1:0] {
        HALT    = 2'd0,
        FETCH   = 2'd1,
        EXECUTE = 2'd2
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_STR  = 4'h7;
    localparam logic [3:0] OP_LDR  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_JC   = 4'hB;
    localparam logic [3:0] OP_JSW  = 4'hC;
    localparam logic [3:0] OP_ADDI = 4'hD;
    localparam logic [3:0] OP_NOT  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Instruction words are {opcode, operand}; callers zero-extend the word and
    // cast the result back to their own field width.
    function automatic logic [63:0] instr_opcode(input logic [63:0] word,
                                                 input int unsigned reg_w);
        return word >> reg_w;
    endfunction

    function automatic logic [63:0] instr_operand(input logic [63:0] word,
                                                  input int unsigned reg_w);
        return word & ((64'd1 << reg_w) - 64'd1);
    endfunction

endpackage

// File: rtl/puc_program_mem.sv
// rtl/puc_program_mem.sv - program store with one sync write port and one sync read port
module puc_program_mem #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 12
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Array contents are deliberately unreset so a program survives a core reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // The read register doubles as the instruction register, so it does reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/puc_cpu_core.sv
// rtl/puc_cpu_core.sv - accumulator CPU core; optional PUC_SWITCH_SYNC_EN adds switch synchronisers
module puc_cpu_core
    import puc_pkg::*;
#(
    parameter int REGISTER_WIDTH = 8,
    parameter int PC_WIDTH       = 5,
    parameter int OPCODE_WIDTH   = 4,
    parameter int NUM_REGISTERS  = 4,
    parameter int NUM_SWITCHES   = 2
) (
    input  logic                             clock,
    input  logic                             isReset,
    input  logic                             run,
    input  logic                             step,
    input  logic [NUM_SWITCHES-1:0]          switch,
    input  logic                             progWe,
    input  logic [PC_WIDTH-1:0]              progAddr,
    input  logic [OPCODE_WIDTH+REGISTER_WIDTH-1:0] progData,
    input  logic [$clog2(NUM_REGISTERS)-1:0] debugSel,
    output logic [PC_WIDTH-1:0]              pc,
    output logic [REGISTER_WIDTH-1:0]        accumulator,
    output logic [OPCODE_WIDTH-1:0]          opCode,
    output logic [REGISTER_WIDTH-1:0]        debugValue,
    output logic                             carry,
    output logic                             halted
);

    localparam int RIDX_W  = $clog2(NUM_REGISTERS);
    localparam int INSTR_W = OPCODE_WIDTH + REGISTER_WIDTH;

    state_t                    state_q, state_d;
    logic                      stepping_q, stepping_d;
    logic [PC_WIDTH-1:0]       pc_q, pc_d;
    logic [REGISTER_WIDTH-1:0] acc_q, acc_d;
    logic                      carry_q, carry_d;
    logic [REGISTER_WIDTH-1:0] regs_q [NUM_REGISTERS];
    logic                      reg_we;
    logic                      fetch_en;

    logic [INSTR_W-1:0]        ir;
    logic [OPCODE_WIDTH-1:0]   ir_op;
    logic [REGISTER_WIDTH-1:0] imm;
    logic [31:0]               op_ext;
    logic [3:0]                dec_op;
    logic [RIDX_W-1:0]         rsel;
    logic [REGISTER_WIDTH-1:0] rval;
    logic [REGISTER_WIDTH:0]   sum_r, diff_r, sum_i;
    logic [PC_WIDTH-1:0]       jmp_target;
    logic [NUM_SWITCHES-1:0]   sw_eff;
    logic                      sw_bit;

    puc_program_mem #(
        .ADDR_W (PC_WIDTH),
        .DATA_W (INSTR_W)
    ) u_mem (
        .clk_i   (clock),
        .rst_n_i (isReset),
        .we_i    (progWe && (state_q == HALT)),
        .waddr_i (progAddr),
        .wdata_i (progData),
        .re_i    (fetch_en),
        .raddr_i (pc_q),
        .rdata_o (ir)
    );

`ifdef PUC_SWITCH_SYNC_EN
    logic [NUM_SWITCHES-1:0] sw_meta_q, sw_sync_q;

    // Two-flop synchroniser for asynchronous user switches.
    always_ff @(posedge clock or negedge isReset) begin
        if (!isReset) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= switch;
            sw_sync_q <= sw_meta_q;
        end
    end

    assign sw_eff = sw_sync_q;
`else
    assign sw_eff = switch;
`endif

    assign ir_op      = OPCODE_WIDTH'(instr_opcode(64'(ir), REGISTER_WIDTH));
    assign imm        = REGISTER_WIDTH'(instr_operand(64'(ir), REGISTER_WIDTH));
    assign op_ext     = 32'(ir_op);
    // Opcodes beyond the 4-bit table behave as NOP.
    assign dec_op     = (op_ext < 32'd16) ? op_ext[3:0] : OP_NOP;
    assign rsel       = imm[RIDX_W-1:0];
    assign rval       = regs_q[rsel];
    assign sum_r      = {1'b0, acc_q} + {1'b0, rval};
    assign diff_r     = {1'b0, acc_q} - {1'b0, rval};
    assign sum_i      = {1'b0, acc_q} + {1'b0, imm};
    assign jmp_target = PC_WIDTH'(imm);

    // Select switch[imm mod NUM_SWITCHES]; NUM_SWITCHES need not be a power of two.
    always_comb begin
        sw_bit = 1'b0;
        for (int i = 0; i < NUM_SWITCHES; i++) begin
            if ((32'(imm) % 32'(NUM_SWITCHES)) == 32'(i)) begin
                sw_bit = sw_eff[i];
            end
        end
    end

    // FSM state and stepping flag registers.
    always_ff @(posedge clock or negedge isReset) begin
        if (!isReset) begin
            state_q    <= HALT;
            stepping_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            stepping_q <= stepping_d;
        end
    end

    // FSM next state: run beats step, stepping returns to HALT after one instruction.
    always_comb begin
        state_d    = state_q;
        stepping_d = stepping_q;
        fetch_en   = 1'b0;
        case (state_q)
            HALT: begin
                if (run) begin
                    state_d    = FETCH;
                    stepping_d = 1'b0;
                end else if (step) begin
                    state_d    = FETCH;
                    stepping_d = 1'b1;
                end
            end
            FETCH: begin
                fetch_en = 1'b1;
                state_d  = EXECUTE;
            end
            EXECUTE: begin
                if ((dec_op == OP_HALT) || stepping_q) begin
                    state_d    = HALT;
                    stepping_d = 1'b0;
                end else begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d    = HALT;
                stepping_d = 1'b0;
            end
        endcase
    end

    // Datapath next state: only the EXECUTE cycle changes architectural state.
    always_comb begin
        pc_d    = pc_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        reg_we  = 1'b0;
        if (state_q == EXECUTE) begin
            pc_d = pc_q + PC_WIDTH'(1);
            case (dec_op)
                OP_LDI:  acc_d = imm;
                OP_ADD: begin
                    acc_d   = sum_r[REGISTER_WIDTH-1:0];
                    carry_d = sum_r[REGISTER_WIDTH];
                end
                OP_SUB: begin
                    acc_d   = diff_r[REGISTER_WIDTH-1:0];
                    carry_d = diff_r[REGISTER_WIDTH];
                end
                OP_AND:  acc_d = acc_q & rval;
                OP_OR:   acc_d = acc_q | rval;
                OP_XOR:  acc_d = acc_q ^ rval;
                OP_STR:  reg_we = 1'b1;
                OP_LDR:  acc_d = rval;
                OP_JMP:  pc_d = jmp_target;
                OP_JZ:   if (acc_q == '0) pc_d = jmp_target;
                OP_JC:   if (carry_q) pc_d = jmp_target;
                OP_JSW:  if (sw_bit) pc_d = jmp_target;
                OP_ADDI: begin
                    acc_d   = sum_i[REGISTER_WIDTH-1:0];
                    carry_d = sum_i[REGISTER_WIDTH];
                end
                OP_NOT:  acc_d = ~acc_q;
                default: ;
            endcase
        end
    end

    // Architectural registers: pc, accumulator, carry.
    always_ff @(posedge clock or negedge isReset) begin
        if (!isReset) begin
            pc_q    <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
        end
    end

    // Register file, written only by STR.
    always_ff @(posedge clock or negedge isReset) begin
        if (!isReset) begin
            for (int i = 0; i < NUM_REGISTERS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (reg_we) begin
            regs_q[rsel] <= acc_q;
        end
    end

    assign pc          = pc_q;
    assign accumulator = acc_q;
    assign opCode      = ir_op;
    assign debugValue  = regs_q[debugSel];
    assign carry       = carry_q;
    assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_puc_cpu_core.sv
// tb/tb_puc_cpu_core.sv - self-checking bench for puc_cpu_core against an ISA-level model
module tb_puc_cpu_core;

    logic        clock = 1'b0;
    logic        isReset = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic [1:0]  switch = 2'b00;
    logic        progWe = 1'b0;
    logic [4:0]  progAddr = 5'd0;
    logic [11:0] progData = 12'd0;
    logic [1:0]  debugSel = 2'd0;
    logic [4:0]  pc;
    logic [7:0]  accumulator;
    logic [3:0]  opCode;
    logic [7:0]  debugValue;
    logic        carry;
    logic        halted;

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    puc_cpu_core dut (
        .clock       (clock),
        .isReset     (isReset),
        .run         (run),
        .step        (step),
        .switch      (switch),
        .progWe      (progWe),
        .progAddr    (progAddr),
        .progData    (progData),
        .debugSel    (debugSel),
        .pc          (pc),
        .accumulator (accumulator),
        .opCode      (opCode),
        .debugValue  (debugValue),
        .carry       (carry),
        .halted      (halted)
    );

    always #5 clock = ~clock;

    // ---------------- ISA-level model ----------------
    logic [11:0] m_mem [32];
    int          m_pc, m_acc, m_c, m_ir;
    int          m_r [4];
    bit          m_halted, m_step, m_fetched;
    logic [1:0]  m_s1, m_s2, m_sw_used;

    task automatic isa_exec(input logic [1:0] sw);
        int op, imm, rv, nxt;
        op  = m_ir / 256;
        imm = m_ir % 256;
        rv  = m_r[imm % 4];
        nxt = (m_pc + 1) % 32;
        case (op)
            1:  m_acc = imm;
            2:  begin m_c = (m_acc + rv > 255); m_acc = (m_acc + rv) % 256; end
            3:  begin m_c = (m_acc < rv); m_acc = (m_acc - rv + 256) % 256; end
            4:  m_acc = m_acc & rv;
            5:  m_acc = m_acc | rv;
            6:  m_acc = m_acc ^ rv;
            7:  m_r[imm % 4] = m_acc;
            8:  m_acc = rv;
            9:  nxt = imm % 32;
            10: if (m_acc == 0) nxt = imm % 32;
            11: if (m_c != 0) nxt = imm % 32;
            12: if (sw[imm % 2]) nxt = imm % 32;
            13: begin m_c = (m_acc + imm > 255); m_acc = (m_acc + imm) % 256; end
            14: m_acc = 255 - m_acc;
            default: ;
        endcase
        m_pc = nxt;
    endtask

    initial begin : model
        forever begin
            @(posedge clock or negedge isReset);
            if (!isReset) begin
                m_pc = 0; m_acc = 0; m_c = 0; m_ir = 0;
                for (int i = 0; i < 4; i++) m_r[i] = 0;
                m_halted = 1'b1; m_step = 1'b0; m_fetched = 1'b0;
                m_s1 = 2'b00; m_s2 = 2'b00;
            end else begin
`ifdef PUC_SWITCH_SYNC_EN
                m_sw_used = m_s2;
`else
                m_sw_used = switch;
`endif
                if (m_halted) begin
                    if (progWe) m_mem[progAddr] = progData;
                    if (run || step) begin
                        m_halted = 1'b0;
                        m_step = !run;
                        m_fetched = 1'b0;
                    end
                end else if (!m_fetched) begin
                    m_ir = int'(m_mem[5'(m_pc)]);
                    m_fetched = 1'b1;
                end else begin
                    isa_exec(m_sw_used);
                    m_fetched = 1'b0;
                    if ((m_ir / 256) == 15 || m_step) m_halted = 1'b1;
                end
                m_s2 = m_s1;
                m_s1 = switch;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    initial begin : compare
        forever begin
            @(negedge clock);
            if (chk_en) begin
                check("pc", 32'(pc), m_pc);
                check("accumulator", 32'(accumulator), m_acc);
                check("carry", 32'(carry), m_c);
                check("halted", 32'(halted), 32'(m_halted));
                check("opCode", 32'(opCode), m_ir / 256);
                check("debugValue", 32'(debugValue), m_r[debugSel]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic load(input int a, input int op, input int imm);
        progAddr = 5'(a);
        progData = 12'(op * 256 + imm);
        progWe = 1'b1;
        tick(1);
        progWe = 1'b0;
    endtask

    task automatic do_reset();
        isReset = 1'b0;
        tick(2);
        isReset = 1'b1;
        tick(1);
    endtask

    task automatic wait_halt(input int max);
        for (int k = 0; k < max && !halted; k++) tick(1);
        check("halt_reached", 32'(halted), 32'd1);
    endtask

    task automatic run_prog();
        run = 1'b1;
        tick(1);
        run = 1'b0;
        wait_halt(300);
    endtask

    task automatic step_one();
        step = 1'b1;
        tick(1);
        step = 1'b0;
        tick(2);
    endtask

    initial begin : stimulus
        bit saw31, wrapped, found;

        // Reset and idle
        tick(3);
        isReset = 1'b1;
        chk_en = 1'b1;
        tick(10);
        check("idle_halted", 32'(halted), 32'd1);
        check("idle_pc", 32'(pc), 32'd0);
        check("idle_acc", 32'(accumulator), 32'd0);
        check("idle_carry", 32'(carry), 32'd0);

        // Arithmetic and carry
        load(0, 1, 'hF0); load(1, 7, 1); load(2, 1, 'h20); load(3, 2, 1); load(4, 15, 0);
        run_prog();
        check("arith_acc", 32'(accumulator), 32'h10);
        check("arith_carry", 32'(carry), 32'd1);
        check("arith_pc", 32'(pc), 32'd5);
        debugSel = 2'd1;
        #1;
        check("arith_r1", 32'(debugValue), 32'hF0);
        debugSel = 2'd0;

        // Single step
        do_reset();
        step_one();
        check("step1_acc", 32'(accumulator), 32'hF0);
        check("step1_pc", 32'(pc), 32'd1);
        check("step1_halted", 32'(halted), 32'd1);
        for (int i = 0; i < 3; i++) step_one();
        check("step4_acc", 32'(accumulator), 32'h10);
        check("step4_carry", 32'(carry), 32'd1);
        check("step4_pc", 32'(pc), 32'd4);
        step_one();
        check("step5_pc", 32'(pc), 32'd5);
        check("step5_halted", 32'(halted), 32'd1);

        // Switch branch
        load(0, 12, 4); load(1, 1, 'h11); load(2, 15, 0);
        load(3, 0, 0); load(4, 1, 'h22); load(5, 15, 0);
        do_reset();
        switch = 2'b00;
        tick(2);
        run_prog();
        check("sw0_acc", 32'(accumulator), 32'h11);
        check("sw0_pc", 32'(pc), 32'd3);
        do_reset();
        switch = 2'b01;
        tick(2);
        run_prog();
        check("sw1_acc", 32'(accumulator), 32'h22);
        check("sw1_pc", 32'(pc), 32'd6);
        switch = 2'b00;

        // Logic ops, JZ, JC, ADDI wrap, NOT, LDR
        load(0, 1, 'h0C); load(1, 7, 0); load(2, 1, 'h0A); load(3, 4, 0);
        load(4, 5, 0); load(5, 6, 0); load(6, 10, 9); load(7, 1, 'hFF);
        load(8, 15, 0); load(9, 14, 0); load(10, 13, 1); load(11, 11, 13);
        load(12, 15, 0); load(13, 8, 0); load(14, 15, 0);
        do_reset();
        run_prog();
        check("mix_acc", 32'(accumulator), 32'h0C);
        check("mix_carry", 32'(carry), 32'd1);
        check("mix_pc", 32'(pc), 32'd15);

        // PC wrap with an all-NOP program
        for (int a = 0; a < 32; a++) load(a, 0, 0);
        do_reset();
        run = 1'b1;
        tick(1);
        run = 1'b0;
        saw31 = 1'b0;
        wrapped = 1'b0;
        repeat (90) begin
            tick(1);
            if (pc == 5'd31) saw31 = 1'b1;
            else if (saw31 && pc == 5'd0) wrapped = 1'b1;
        end
        check("wrap_seen", 32'(wrapped), 32'd1);
        check("wrap_running", 32'(halted), 32'd0);
        do_reset();

        // SUB underflow
        load(0, 1, 1); load(1, 7, 2); load(2, 1, 0); load(3, 3, 2); load(4, 15, 0);
        do_reset();
        run_prog();
        check("sub_acc", 32'(accumulator), 32'hFF);
        check("sub_carry", 32'(carry), 32'd1);
        check("sub_pc", 32'(pc), 32'd5);

        // Write protection while running, then reset during EXECUTE
        load(0, 1, 'h5A); load(1, 9, 0);
        do_reset();
        run = 1'b1;
        tick(1);
        run = 1'b0;
        tick(10);
        progAddr = 5'd0;
        progData = 12'hF00;
        progWe = 1'b1;
        tick(3);
        progWe = 1'b0;
        tick(10);
        check("prot_running", 32'(halted), 32'd0);
        check("prot_acc", 32'(accumulator), 32'h5A);
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (m_fetched && !m_halted) begin
                found = 1'b1;
                break;
            end
            tick(1);
        end
        check("exec_found", 32'(found), 32'd1);
        isReset = 1'b0;
        #1;
        check("midrst_pc", 32'(pc), 32'd0);
        check("midrst_acc", 32'(accumulator), 32'd0);
        check("midrst_halted", 32'(halted), 32'd1);
        check("midrst_opcode", 32'(opCode), 32'd0);
        tick(2);
        isReset = 1'b1;
        tick(1);
        run = 1'b1;
        tick(1);
        run = 1'b0;
        tick(12);
        check("rerun_running", 32'(halted), 32'd0);
        check("rerun_acc", 32'(accumulator), 32'h5A);
        do_reset();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
